muon_decay_sequencer: RTL
=========================

Name: muon_decay_sequencer

Overview:
- Run controller that sequences the two-paddle coincidence detector for lifetime measurement.
- Arms the detector and treats its coincidence pulse as "muon stop". It then times the cycles until the decay pulse, or declares a timeout.
- Presents each lifetime on a valid/ready result port, then holds the detector disarmed for a holdoff before re-arming.
- Sits between the coincidence detector and the readout/UART logger.

Parameters:
- TIMEOUT_CYCLES, 2000: max measurement window in clk cycles (20 us at 100 MHz).
- BLANK_CYCLES, 4: decay edges at count <= BLANK_CYCLES are ignored (start-pulse ringing).
- HOLDOFF_CYCLES, 200: cycles disarmed after each event or timeout.
- LT_W, 16: lifetime/counter width; must hold TIMEOUT_CYCLES.
- CNT_W, 16: event/timeout statistics counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, reset is synchronous and active-high.
- run_en  in  1  level; run requested.
- coinc_in  in  1  coincidence_detected from detector (start).
- decay_in  in  1  decay pulse, OR of paddle discriminators, synchronised upstream (stop).
- arm  out  1  detector enable (drives enable_A/enable_B gating).
- res_valid  out  1  lifetime result valid.
- res_ready  in  1  consumer accepts result.
- res_lifetime  out  LT_W  measured cycles.
- decay_count  out  CNT_W  accepted results, saturating.
- timeout_count  out  CNT_W  timed-out starts, saturating.
- busy  out  1  high in MEASURE, REPORT or HOLDOFF.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE.
  - arm=0, res_valid=0, res_lifetime=0, decay_count=0, timeout_count=0, busy=0.
  - Edge-detect history registers cleared.
  - Reset mid-operation discards any pending result with no handshake.
- Rising edges:
  - Registered edge detection on coinc_in and decay_in: edge = in & ~in_q.
  - A level held high produces exactly one edge.
- IDLE:
  - arm=0.
  - run_en=1 -> ARMED next cycle.
- ARMED:
  - arm=1.
  - run_en=0 -> IDLE; this has priority over a same-cycle coinc edge.
  - coinc edge detected in cycle N -> MEASURE at N+1 with cnt=1.
- MEASURE:
  - arm=0; cnt increments by 1 each cycle; coinc edges are ignored.
  - A decay edge in a cycle with cnt > BLANK_CYCLES latches res_lifetime=cnt and moves to REPORT. Lifetime therefore equals the cycles between the start-edge cycle and the stop-edge cycle.
  - Decay edges with cnt <= BLANK_CYCLES are ignored.
  - Timeout: cnt==TIMEOUT_CYCLES with no valid stop -> timeout_count+1 and go to HOLDOFF.
  - A stop edge exactly at cnt==TIMEOUT_CYCLES wins over timeout.
  - run_en is ignored in this state.
- REPORT:
  - res_valid=1; res_lifetime stable until the handshake.
  - res_valid & res_ready -> decay_count+1, res_valid=0 next cycle, go to HOLDOFF.
  - Back-pressure holds the block in REPORT indefinitely; arm stays 0 and no events are lost silently.
- HOLDOFF:
  - arm=0; counts HOLDOFF_CYCLES cycles.
  - Then ARMED if run_en=1, else IDLE.
- Counters saturate at all-ones and never wrap.
- Latencies:
  - Start edge -> arm low: 1 cycle.
  - Stop edge -> res_valid: 1 cycle.

Optional Feature:
- Macro: MUON_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, cleared by rst, wrapping naturally.
  - Adds output res_timestamp (32 bits), latched at the start-edge cycle.
  - res_timestamp is valid and stable under the same res_valid/res_ready rules as res_lifetime.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package muon_pkg holds:
  - the state enum (IDLE, ARMED, MEASURE, REPORT, HOLDOFF);
  - the default timing constants (TIMEOUT, BLANK, HOLDOFF);
  - LT_W and CNT_W defaults, shared with the detector and logger.
- Sub-module rise_edge: one-register rising-edge detector with sync reset, instantiated twice (coinc_in, decay_in).

Test Plan:
- run_en=1, coinc edge at cycle 10, decay edge at cycle 110, res_ready=1 -> res_valid at cycle 111 with res_lifetime=100; decay_count=1; arm low for 100+200 cycles, then high again.
- Decay edge 3 cycles after start, then another at 50 -> first ignored (blanking); res_lifetime=50.
- Start edge with no decay -> at cnt=2000 timeout_count=1, no res_valid; re-arm after 200 holdoff cycles. Decay at exactly cnt=2000 -> res_lifetime=2000, timeout_count unchanged.
- res_ready=0 for 500 cycles after a result -> res_valid and res_lifetime stable; further coinc/decay edges cause no state change; decay_count increments only on the handshake.
- Assert rst during MEASURE and during REPORT -> next cycle all outputs at reset values; state IDLE; re-arm one cycle after rst deasserts with run_en=1.
- MUON_TIMESTAMP_EN defined, starts at cycles 10 and 5000 -> res_timestamp equals the start-edge cycle count for each result.

Source files
------------

// File: rtl/muon_pkg.sv
// Shared types and default constants for the muon lifetime run controller,
// the coincidence detector and the readout logger.
package muon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    MEASURE,
    REPORT,
    HOLDOFF
  } state_e;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 2000;
  localparam int unsigned DEF_BLANK_CYCLES   = 4;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 200;
  localparam int unsigned DEF_LT_W           = 16;
  localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/muon_decay_sequencer_rise_edge.sv
// One-register rising-edge detector; a level held high yields a single pulse.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise_c
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise_c = sig & ~sig_q;

endmodule

// File: rtl/muon_decay_sequencer.sv
// Run controller for the two-paddle muon lifetime measurement: arm, time start->stop,
// report over valid/ready, hold off. Define MUON_TIMESTAMP_EN to add res_timestamp.
module muon_decay_sequencer
  import muon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned LT_W           = DEF_LT_W,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic             coinc_in,
  input  logic             decay_in,
  output logic             arm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [LT_W-1:0]  res_lifetime,
`ifdef MUON_TIMESTAMP_EN
  output logic [31:0]      res_timestamp,
`endif
  output logic [CNT_W-1:0] decay_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic             busy
);

  localparam logic [LT_W-1:0] TIMEOUT_LIM = LT_W'(TIMEOUT_CYCLES);
  localparam logic [LT_W-1:0] BLANK_LIM   = LT_W'(BLANK_CYCLES);
  localparam logic [LT_W-1:0] HOLDOFF_LIM = LT_W'(HOLDOFF_CYCLES);
  localparam logic [LT_W-1:0] CNT_ONE     = LT_W'(1);

  state_e          state;
  logic [LT_W-1:0] cnt;
  logic            coinc_rise_c;
  logic            decay_rise_c;

  rise_edge u_coinc_edge (
    .clk    (clk),
    .rst    (rst),
    .sig    (coinc_in),
    .rise_c (coinc_rise_c)
  );

  rise_edge u_decay_edge (
    .clk    (clk),
    .rst    (rst),
    .sig    (decay_in),
    .rise_c (decay_rise_c)
  );

`ifdef MUON_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clk) begin
    if (rst) ts <= 32'd0;
    else     ts <= ts + 32'd1;
  end
`endif

  // cnt times the measurement window in MEASURE and the dead time in HOLDOFF
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      arm           <= 1'b0;
      res_valid     <= 1'b0;
      res_lifetime  <= '0;
      decay_count   <= '0;
      timeout_count <= '0;
      busy          <= 1'b0;
`ifdef MUON_TIMESTAMP_EN
      res_timestamp <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run_en) begin
            state <= ARMED;
            arm   <= 1'b1;
          end
        end
        ARMED: begin
          if (!run_en) begin
            state <= IDLE;
            arm   <= 1'b0;
          end else if (coinc_rise_c) begin
            state <= MEASURE;
            arm   <= 1'b0;
            busy  <= 1'b1;
            cnt   <= CNT_ONE;
`ifdef MUON_TIMESTAMP_EN
            res_timestamp <= ts;
`endif
          end
        end
        MEASURE: begin
          // a valid stop is tested before the timeout so a stop at the limit still reports
          if (decay_rise_c && (cnt > BLANK_LIM)) begin
            state        <= REPORT;
            res_valid    <= 1'b1;
            res_lifetime <= cnt;
          end else if (cnt == TIMEOUT_LIM) begin
            state <= HOLDOFF;
            cnt   <= CNT_ONE;
            if (timeout_count != '1) timeout_count <= timeout_count + CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state     <= HOLDOFF;
            res_valid <= 1'b0;
            cnt       <= CNT_ONE;
            if (decay_count != '1) decay_count <= decay_count + CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt == HOLDOFF_LIM) begin
            busy <= 1'b0;
            if (run_en) begin
              state <= ARMED;
              arm   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          arm       <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
